// File: rtl/regfile_sb.sv
// General-purpose register file with write-through bypass and a per-register
// pending-write scoreboard used by pipeline control to stall on RAW hazards.
module regfile_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [4:0]        raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [4:0]        raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              issue_we,
    input  logic [4:0]        issue_addr,
    output logic              busy1,
    output logic              busy2,
    output logic              sb_ovf
);

    typedef logic [PEND_W-1:0] pend_t;
    localparam pend_t PendMax = '1;

    logic [DATA_W-1:0] regs_q [NREG];
    pend_t             pend_q [NREG];
    pend_t             pend_d [NREG];
    logic [NREG-1:0]   inc, dec;
    logic              sb_ovf_q, sb_ovf_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                pend_q[i] <= '0;
            end
            sb_ovf_q <= 1'b0;
        end else begin
            if (we && waddr != 5'd0) begin
                regs_q[waddr] <= wdata;
            end
            for (int i = 0; i < NREG; i++) begin
                pend_q[i] <= pend_d[i];
            end
            sb_ovf_q <= sb_ovf_d;
        end
    end

    // Register 0 can never match because both events exclude address 0.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 0; r < NREG; r++) begin
            inc[r] = issue_we && issue_addr != 5'd0 && issue_addr == 5'(r);
            dec[r] = we && waddr != 5'd0 && waddr == 5'(r) && pend_q[r] != '0;
        end
    end

    always_comb begin
        sb_ovf_d = sb_ovf_q;
        for (int r = 0; r < NREG; r++) begin
            pend_d[r] = pend_q[r];
            if (inc[r] && !dec[r]) begin
                if (pend_q[r] == PendMax) begin
                    sb_ovf_d = 1'b1;
                end else begin
                    pend_d[r] = pend_q[r] + 1'b1;
                end
            end else if (dec[r] && !inc[r]) begin
                pend_d[r] = pend_q[r] - 1'b1;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic re, input logic [4:0] addr);
        if (!re || addr == 5'd0) begin
            return '0;
        end else if (we && waddr == addr) begin
            return wdata;
        end
        return regs_q[addr];
    endfunction

    // A single outstanding write landing this cycle is covered by the bypass.
    function automatic logic busy_port(input logic re, input logic [4:0] addr);
        if (!re || addr == 5'd0 || pend_q[addr] == '0) begin
            return 1'b0;
        end
        return !(pend_q[addr] == pend_t'(1) && we && waddr == addr);
    endfunction

    always_comb begin
        rdata1 = read_port(re1, raddr1);
        rdata2 = read_port(re2, raddr2);
        busy1  = busy_port(re1, raddr1);
        busy2  = busy_port(re2, raddr2);
        sb_ovf = sb_ovf_q;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: expectations are queued when stimulus is applied
// and popped/compared once the combinational outputs have settled.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        re1 = 1'b0;
    logic [4:0]  raddr1 = '0;
    logic [31:0] rdata1;
    logic        re2 = 1'b0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rdata2;
    logic        issue_we = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic        busy1, busy2, sb_ovf;

    regfile_sb #(.DATA_W(32), .NREG(32), .PEND_W(2)) dut (
        .clk(clk), .rst(rst),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .issue_we(issue_we), .issue_addr(issue_addr),
        .busy1(busy1), .busy2(busy2), .sb_ovf(sb_ovf)
    );

    always #5 clk = ~clk;

    typedef enum int {SelRd1, SelRd2, SelBusy1, SelBusy2, SelOvf} sel_t;
    typedef struct {
        string       tag;
        sel_t        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] observe(input sel_t sel);
        case (sel)
            SelRd1:   return rdata1;
            SelRd2:   return rdata2;
            SelBusy1: return {31'd0, busy1};
            SelBusy2: return {31'd0, busy2};
            default:  return {31'd0, sb_ovf};
        endcase
    endfunction

    task automatic expect_val(input string tag, input sel_t sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observe(e.sel);
            n_vec++;
            assert (obs === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Check on the falling edge, then advance past the next rising edge.
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        issue_we = 1'b0; issue_addr = '0;
    endtask

    initial begin
        // 1. Reset
        idle();
        re1 = 1'b1; raddr1 = 5'd7;
        expect_val("in_reset_rd1", SelRd1, 32'h0);
        expect_val("in_reset_ovf", SelOvf, 32'h0);
        cycle();
        rst = 1'b1;
        #1;
        for (int a = 0; a < 32; a++) begin
            re1 = 1'b1; raddr1 = 5'(a);
            re2 = 1'b1; raddr2 = 5'(31 - a);
            expect_val($sformatf("rst_rd1_%0d", a), SelRd1, 32'h0);
            expect_val($sformatf("rst_rd2_%0d", a), SelRd2, 32'h0);
            expect_val($sformatf("rst_busy1_%0d", a), SelBusy1, 32'h0);
            expect_val($sformatf("rst_busy2_%0d", a), SelBusy2, 32'h0);
            expect_val($sformatf("rst_ovf_%0d", a), SelOvf, 32'h0);
            cycle();
        end

        // 2. Write/read with bypass
        idle();
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd6;
        expect_val("wr_bypass_rd1", SelRd1, 32'hDEADBEEF);
        expect_val("wr_other_rd2", SelRd2, 32'h0);
        cycle();
        idle();
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
        expect_val("wr_stored_rd1", SelRd1, 32'hDEADBEEF);
        expect_val("wr_stored_rd2", SelRd2, 32'hDEADBEEF);
        cycle();
        idle();
        raddr1 = 5'd5;
        expect_val("wr_re_off_rd1", SelRd1, 32'h0);
        cycle();

        // 3. Register 0
        idle();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        issue_we = 1'b1; issue_addr = 5'd0;
        re1 = 1'b1; raddr1 = 5'd0;
        expect_val("r0_same_rd1", SelRd1, 32'h0);
        expect_val("r0_same_busy1", SelBusy1, 32'h0);
        cycle();
        idle();
        re1 = 1'b1; raddr1 = 5'd0;
        expect_val("r0_next_rd1", SelRd1, 32'h0);
        expect_val("r0_next_busy1", SelBusy1, 32'h0);
        cycle();

        // 4. Hazard on register 8
        idle();
        issue_we = 1'b1; issue_addr = 5'd8; re2 = 1'b1; raddr2 = 5'd8;
        expect_val("hz_issue0_busy2", SelBusy2, 32'h0);
        cycle();
        expect_val("hz_issue1_busy2", SelBusy2, 32'h1);
        cycle();
        idle();
        re2 = 1'b1; raddr2 = 5'd8;
        expect_val("hz_pend2_busy2", SelBusy2, 32'h1);
        cycle();
        we = 1'b1; waddr = 5'd8; wdata = 32'h11;
        expect_val("hz_wb1_busy2", SelBusy2, 32'h1);
        expect_val("hz_wb1_rd2", SelRd2, 32'h11);
        cycle();
        wdata = 32'h22;
        expect_val("hz_wb2_busy2", SelBusy2, 32'h0);
        expect_val("hz_wb2_rd2", SelRd2, 32'h22);
        cycle();
        idle();
        re2 = 1'b1; raddr2 = 5'd8;
        expect_val("hz_done_busy2", SelBusy2, 32'h0);
        expect_val("hz_done_rd2", SelRd2, 32'h22);
        cycle();
        we = 1'b1; waddr = 5'd8; wdata = 32'h33;
        cycle();
        idle();
        re2 = 1'b1; raddr2 = 5'd8;
        expect_val("hz_extra_wb_busy2", SelBusy2, 32'h0);
        expect_val("hz_extra_wb_rd2", SelRd2, 32'h33);
        expect_val("hz_extra_wb_ovf", SelOvf, 32'h0);
        cycle();

        // 5. Simultaneous issue and write-back on register 3
        idle();
        issue_we = 1'b1; issue_addr = 5'd3;
        cycle();
        we = 1'b1; waddr = 5'd3; wdata = 32'h44; re1 = 1'b1; raddr1 = 5'd3;
        expect_val("sim_same_busy1", SelBusy1, 32'h0);
        expect_val("sim_same_rd1", SelRd1, 32'h44);
        cycle();
        idle();
        re1 = 1'b1; raddr1 = 5'd3;
        expect_val("sim_next_busy1", SelBusy1, 32'h1);
        expect_val("sim_next_rd1", SelRd1, 32'h44);
        cycle();

        // 6. Overflow on register 9, then asynchronous reset
        idle();
        re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd5;
        for (int k = 0; k < 4; k++) begin
            issue_we = 1'b1; issue_addr = 5'd9;
            expect_val($sformatf("ovf_pre%0d", k), SelOvf, 32'h0);
            expect_val($sformatf("ovf_busy_pre%0d", k), SelBusy1, (k == 0) ? 32'h0 : 32'h1);
            cycle();
        end
        issue_we = 1'b0;
        expect_val("ovf_set", SelOvf, 32'h1);
        expect_val("ovf_sat_busy1", SelBusy1, 32'h1);
        cycle();
        // Two write-backs from a held count of 3 must still leave register 9 busy.
        we = 1'b1; waddr = 5'd9; wdata = 32'h99;
        cycle();
        cycle();
        we = 1'b0;
        expect_val("ovf_held_busy1", SelBusy1, 32'h1);
        expect_val("ovf_sticky", SelOvf, 32'h1);
        @(negedge clk);
        check_all();
        #2;
        rst = 1'b0;
        #1;
        expect_val("async_ovf", SelOvf, 32'h0);
        expect_val("async_busy1", SelBusy1, 32'h0);
        expect_val("async_rd2", SelRd2, 32'h0);
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
